sw_watch_ctrl: RTL and testbench
================================

Name: sw_watch_ctrl

Overview:
Central mode/sequence controller for the stopwatch/watch design. Consumes the one-cycle button pulses from the per-button pulse generators and the mode switch. Produces registered control strobes and levels for the stopwatch counter datapath (run, clear) and the watch time-set datapath (field select, increment/decrement). Sits between the button pulse generators and both counter datapaths.

Parameters:
TIMEOUT_S, 10, idle seconds before the watch auto-exits set mode (used only with the optional feature)
TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_S

Ports:
clk         input   1  system clock
rst         input   1  reset, asynchronous, active-high
sw_mode     input   1  0 = stopwatch, 1 = watch; already synchronised upstream
btn_run_p   input   1  one-cycle pulse, right button
btn_clr_p   input   1  one-cycle pulse, left button
btn_up_p    input   1  one-cycle pulse, up button
btn_dn_p    input   1  one-cycle pulse, down button
tick_1hz    input   1  one-cycle strobe, once per second
sw_run      output  1  stopwatch counter enable (level)
sw_clear    output  1  stopwatch counter clear, one-cycle strobe
sw_state    output  2  00 STOP, 01 RUN, 10 CLEAR
set_active  output  1  watch is in a set state
set_field   output  2  00 none, 01 hour, 10 min, 11 sec
inc_p       output  1  one-cycle increment strobe to the selected watch field
dec_p       output  1  one-cycle decrement strobe to the selected watch field

Behaviour:
- Reset is asynchronous, active-high, with clock clk. All outputs are registered. Reset values are 0 for every output: sw_state=STOP, set_field=00.
- Latency: an input pulse at edge N is reflected on the outputs after edge N+1. Exactly one cycle, for every path.

Button routing:
- Buttons act only on the FSM selected by sw_mode. Pulses for the other mode are dropped.
- The stopwatch FSM keeps its state, and keeps running, while sw_mode=1.

Stopwatch FSM (sw_state):
- STOP -> RUN on btn_run_p.
- STOP -> CLEAR on btn_clr_p when btn_run_p=0.
- RUN -> STOP on btn_run_p. btn_clr_p is ignored in RUN.
- CLEAR -> STOP unconditionally after 1 cycle. All buttons are ignored in CLEAR.
- Simultaneous btn_run_p and btn_clr_p in STOP: run wins.
- sw_run = (state==RUN). sw_clear = (state==CLEAR).

Watch FSM:
- States: NORMAL -> SET_HOUR -> SET_MIN -> SET_SEC -> NORMAL. Each advance is one btn_clr_p.
- btn_run_p in any SET state returns to NORMAL immediately.
- btn_run_p together with btn_clr_p: btn_run_p wins.
- set_field encodes the state (NORMAL=00). set_active = (set_field != 00).

Increment/decrement:
- In a SET state, btn_up_p produces inc_p and btn_dn_p produces dec_p, one cycle later.
- Both up and down in the same cycle: neither strobe is issued.
- A state change in the same cycle as btn_up_p or btn_dn_p: the inc/dec pulse is suppressed.
- In NORMAL, inc_p and dec_p stay 0.

Mode change and reset:
- sw_mode falling 1->0 while in a SET state forces the watch FSM to NORMAL on the next edge. No inc_p or dec_p is issued.
- rst asserted mid-operation forces all FSMs to their reset states at once. This holds even mid-CLEAR: the sw_clear strobe is cut.

Optional Feature:
Macro SET_TIMEOUT_EN.
- Defined:
  - A TO_W-bit idle counter clears on entering a SET state and on any button pulse while in a SET state.
  - Otherwise it increments on tick_1hz while in a SET state.
  - When it reaches TIMEOUT_S, the watch FSM returns to NORMAL on the next edge and the counter clears.
  - Outside SET states the counter is held at 0.
- Not defined: no counter exists and a SET state persists indefinitely. tick_1hz is unused and TO_W is unused.

Decomposition:
- Shared package holds:
  - stopwatch state constants: ST_STOP=2'b00, ST_RUN=2'b01, ST_CLEAR=2'b10
  - watch field constants: F_NONE=2'b00, F_HOUR=2'b01, F_MIN=2'b10, F_SEC=2'b11
- One natural sub-module, sw_set_timeout: the idle counter. It has inputs clk, rst, active, activity, tick and output expire. It is instantiated only under SET_TIMEOUT_EN.
- Both FSMs stay in the top module.

Test Plan:
- Reset, sw_mode=0:
  - btn_run_p at cycle 5 -> sw_run=1 from cycle 6.
  - btn_run_p at cycle 20 -> sw_run=0 from cycle 21.
- In STOP, btn_clr_p at cycle 10 -> sw_clear=1 only in cycle 11, sw_state=10 then 00.
- In STOP, btn_run_p and btn_clr_p together -> sw_state=RUN, sw_clear stays 0.
- In RUN, btn_clr_p -> no sw_clear pulse.
- sw_mode=1:
  - 4× btn_clr_p -> set_field sequence 01,10,11,00.
  - btn_up_p in SET_MIN -> inc_p=1 for exactly one cycle.
  - btn_up_p and btn_dn_p together -> no inc_p or dec_p.
- In SET_HOUR, toggle sw_mode to 0 -> set_field=00 next cycle.
- The stopwatch started before entering watch mode still shows sw_run=1 after returning to stopwatch mode.
- With SET_TIMEOUT_EN and TIMEOUT_S=3:
  - enter SET_SEC, then 3 tick_1hz with no buttons -> set_field=00 after the 3rd tick.
  - a btn_up_p after the 2nd tick restarts the count.

Source files
------------

// File: rtl/sw_watch_ctrl_pkg.sv
// Shared constants and state types for the stopwatch/watch mode controller.
package sw_watch_ctrl_pkg;

    // Stopwatch state encodings (also the sw_state output encoding)
    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    // Watch set-field encodings (also the set_field output encoding)
    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_HOUR = 2'b01;
    localparam logic [1:0] F_MIN  = 2'b10;
    localparam logic [1:0] F_SEC  = 2'b11;

    typedef enum logic [1:0] {
        SW_STOP  = ST_STOP,
        SW_RUN   = ST_RUN,
        SW_CLEAR = ST_CLEAR
    } sw_state_t;

    // Watch states share the field encoding so set_field is the state itself
    typedef enum logic [1:0] {
        W_NORMAL   = F_NONE,
        W_SET_HOUR = F_HOUR,
        W_SET_MIN  = F_MIN,
        W_SET_SEC  = F_SEC
    } watch_state_t;

endpackage

// File: rtl/sw_set_timeout.sv
// Idle counter for watch set mode: counts tick strobes while a set state is
// active and no button activity occurs; flags expiry at TIMEOUT_S.
module sw_set_timeout #(
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned TO_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic activity,
    input  logic tick,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_S);

    logic [TO_W-1:0] r_count;

    assign expire = (r_count == LIMIT);

    // Held at zero outside set states; restarts on activity or expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!active || activity || expire) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sw_watch_ctrl.sv
// Mode/sequence controller for the stopwatch/watch design.
// Stopwatch FSM drives sw_run/sw_clear/sw_state; watch FSM drives the
// time-set field select and inc/dec strobes. All outputs registered.
// Optional build macro SET_TIMEOUT_EN: idle auto-exit from set mode.
module sw_watch_ctrl
    import sw_watch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned TO_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_mode,
    input  logic       btn_run_p,
    input  logic       btn_clr_p,
    input  logic       btn_up_p,
    input  logic       btn_dn_p,
    input  logic       tick_1hz,
    output logic       sw_run,
    output logic       sw_clear,
    output logic [1:0] sw_state,
    output logic       set_active,
    output logic [1:0] set_field,
    output logic       inc_p,
    output logic       dec_p
);

    sw_state_t    r_sw_state, w_sw_next;
    watch_state_t r_w_state,  w_w_next;

    logic r_sw_run, r_sw_clear, r_set_active, r_inc, r_dec;
    logic w_sw_run_n, w_sw_clear_n, w_set_active_n, w_inc_n, w_dec_n;
    logic w_in_set, w_expire;

    assign w_in_set = (r_w_state != W_NORMAL);

`ifdef SET_TIMEOUT_EN
    logic w_activity;

    // Leaving watch mode also counts as activity so the counter never
    // holds a stale count once the set state is abandoned.
    assign w_activity = !sw_mode | btn_run_p | btn_clr_p | btn_up_p | btn_dn_p;

    sw_set_timeout #(
        .TIMEOUT_S (TIMEOUT_S),
        .TO_W      (TO_W)
    ) u_set_timeout (
        .clk      (clk),
        .rst      (rst),
        .active   (w_in_set),
        .activity (w_activity),
        .tick     (tick_1hz),
        .expire   (w_expire)
    );
`else
    logic w_unused;

    assign w_expire = 1'b0;
    assign w_unused = tick_1hz ^ (TIMEOUT_S == 0) ^ (TO_W == 0);
`endif

    // Stopwatch next state; buttons only act in stopwatch mode
    always_comb begin
        w_sw_next = r_sw_state;
        unique case (r_sw_state)
            SW_STOP: begin
                if (!sw_mode) begin
                    if (btn_run_p) begin
                        w_sw_next = SW_RUN;
                    end else if (btn_clr_p) begin
                        w_sw_next = SW_CLEAR;
                    end
                end
            end
            SW_RUN: begin
                if (!sw_mode && btn_run_p) begin
                    w_sw_next = SW_STOP;
                end
            end
            SW_CLEAR: w_sw_next = SW_STOP;
            default:  w_sw_next = SW_STOP;
        endcase
        w_sw_run_n   = (w_sw_next == SW_RUN);
        w_sw_clear_n = (w_sw_next == SW_CLEAR);
    end

    // Watch next state and inc/dec strobes; run aborts set mode and wins over clr
    always_comb begin
        w_w_next = r_w_state;
        w_inc_n  = 1'b0;
        w_dec_n  = 1'b0;
        if (!sw_mode || (w_in_set && w_expire) || btn_run_p) begin
            w_w_next = W_NORMAL;
        end else if (btn_clr_p) begin
            unique case (r_w_state)
                W_NORMAL:   w_w_next = W_SET_HOUR;
                W_SET_HOUR: w_w_next = W_SET_MIN;
                W_SET_MIN:  w_w_next = W_SET_SEC;
                W_SET_SEC:  w_w_next = W_NORMAL;
                default:    w_w_next = W_NORMAL;
            endcase
        end
        if (sw_mode && w_in_set && (w_w_next == r_w_state) && (btn_up_p ^ btn_dn_p)) begin
            w_inc_n = btn_up_p;
            w_dec_n = btn_dn_p;
        end
        w_set_active_n = (w_w_next != W_NORMAL);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_state   <= SW_STOP;
            r_w_state    <= W_NORMAL;
            r_sw_run     <= 1'b0;
            r_sw_clear   <= 1'b0;
            r_set_active <= 1'b0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
        end else begin
            r_sw_state   <= w_sw_next;
            r_w_state    <= w_w_next;
            r_sw_run     <= w_sw_run_n;
            r_sw_clear   <= w_sw_clear_n;
            r_set_active <= w_set_active_n;
            r_inc        <= w_inc_n;
            r_dec        <= w_dec_n;
        end
    end

    assign sw_run     = r_sw_run;
    assign sw_clear   = r_sw_clear;
    assign sw_state   = r_sw_state;
    assign set_active = r_set_active;
    assign set_field  = r_w_state;
    assign inc_p      = r_inc;
    assign dec_p      = r_dec;

endmodule

// File: tb/tb_sw_watch_ctrl.sv
// Self-checking bench for sw_watch_ctrl: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a
// behavioural model. Honors SET_TIMEOUT_EN when defined.
module tb_sw_watch_ctrl;

    localparam int TOUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_mode = 1'b0;
    logic       btn_run_p = 1'b0, btn_clr_p = 1'b0, btn_up_p = 1'b0, btn_dn_p = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       sw_run, sw_clear, set_active, inc_p, dec_p;
    logic [1:0] sw_state, set_field;

    int  checks = 0;
    int  errors = 0;
    bit  done = 1'b0;

    // model: stopwatch 0=stop 1=run 2=clear; field 0..3; idle seconds
    int  m_sw = 0, m_field = 0, m_idle = 0;
    bit  m_inc = 1'b0, m_dec = 1'b0;

    always #5 clk = ~clk;

    sw_watch_ctrl #(.TIMEOUT_S(TOUT), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .sw_mode(sw_mode),
        .btn_run_p(btn_run_p), .btn_clr_p(btn_clr_p),
        .btn_up_p(btn_up_p), .btn_dn_p(btn_dn_p), .tick_1hz(tick_1hz),
        .sw_run(sw_run), .sw_clear(sw_clear), .sw_state(sw_state),
        .set_active(set_active), .set_field(set_field),
        .inc_p(inc_p), .dec_p(dec_p)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model advanced on every active edge
    always @(posedge clk or posedge rst) begin
        int  nsw, nf;
        bit  in_set, expired, any;
        if (rst) begin
            m_sw = 0; m_field = 0; m_idle = 0; m_inc = 0; m_dec = 0;
        end else begin
            nsw = m_sw;
            if (m_sw == 2) nsw = 0;
            else if (!sw_mode && btn_run_p) nsw = 1 - m_sw;
            else if (!sw_mode && btn_clr_p && m_sw == 0) nsw = 2;

            in_set  = (m_field != 0);
            any     = btn_run_p | btn_clr_p | btn_up_p | btn_dn_p;
            expired = 1'b0;
`ifdef SET_TIMEOUT_EN
            expired = in_set && (m_idle == TOUT);
`endif
            if (!sw_mode || expired || btn_run_p) nf = 0;
            else if (btn_clr_p) nf = (m_field + 1) % 4;
            else nf = m_field;

            m_inc = sw_mode && in_set && (nf == m_field) && btn_up_p && !btn_dn_p;
            m_dec = sw_mode && in_set && (nf == m_field) && btn_dn_p && !btn_up_p;

            if (!in_set || !sw_mode || any || expired) m_idle = 0;
            else if (tick_1hz) m_idle = m_idle + 1;

            m_sw    = nsw;
            m_field = nf;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!done) begin
            chk("sw_run",     sw_run,     (m_sw == 1));
            chk("sw_clear",   sw_clear,   (m_sw == 2));
            chk("sw_state",   sw_state,   2'(m_sw));
            chk("set_field",  set_field,  2'(m_field));
            chk("set_active", set_active, (m_field != 0));
            chk("inc_p",      inc_p,      m_inc);
            chk("dec_p",      dec_p,      m_dec);
        end
    end

    task automatic step(input bit r, input bit c, input bit u, input bit d, input bit t);
        btn_run_p = r; btn_clr_p = c; btn_up_p = u; btn_dn_p = d; tick_1hz = t;
        @(posedge clk);
        #1;
        btn_run_p = 0; btn_clr_p = 0; btn_up_p = 0; btn_dn_p = 0; tick_1hz = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_state", sw_state, 2'b00);
        chk("rst_run",   sw_run,   1'b0);
        chk("rst_field", set_field, 2'b00);
        chk("rst_inc",   inc_p,    1'b0);

        // stopwatch start/stop/clear
        step(1,0,0,0,0);
        chk("start_run", sw_run, 1'b1);
        chk("start_state", sw_state, 2'b01);
        chk("model_start", 2'(m_sw), 2'd1);
        repeat (3) step(0,0,0,0,0);
        step(1,0,0,0,0);
        chk("stop_run", sw_run, 1'b0);
        step(0,1,0,0,0);
        chk("clr_pulse", sw_clear, 1'b1);
        chk("clr_state", sw_state, 2'b10);
        step(0,0,0,0,0);
        chk("clr_end", sw_clear, 1'b0);
        chk("clr_back", sw_state, 2'b00);
        step(1,1,0,0,0);
        chk("both_state", sw_state, 2'b01);
        chk("both_clear", sw_clear, 1'b0);
        step(0,1,0,0,0);
        chk("run_clr_ign", sw_state, 2'b01);
        chk("run_clr_noclr", sw_clear, 1'b0);

        // watch field cycling
        sw_mode = 1'b1;
        step(0,1,0,0,0); chk("fld_hour", set_field, 2'b01);
        chk("active_on", set_active, 1'b1);
        step(0,1,0,0,0); chk("fld_min", set_field, 2'b10);
        step(0,1,0,0,0); chk("fld_sec", set_field, 2'b11);
        step(0,1,0,0,0); chk("fld_none", set_field, 2'b00);
        chk("active_off", set_active, 1'b0);
        chk("model_fld", 2'(m_field), 2'd0);
        step(0,1,0,0,0); step(0,1,0,0,0);
        step(0,0,1,0,0);
        chk("inc_min", inc_p, 1'b1);
        step(0,0,0,0,0);
        chk("inc_once", inc_p, 1'b0);
        step(0,0,1,1,0);
        chk("updn_inc", inc_p, 1'b0);
        chk("updn_dec", dec_p, 1'b0);
        step(0,0,0,1,0);
        chk("dec_min", dec_p, 1'b1);
        step(0,1,1,0,0);
        chk("chg_sup_inc", inc_p, 1'b0);
        chk("chg_fld", set_field, 2'b11);
        step(1,1,0,0,0);
        chk("run_wins", set_field, 2'b00);
        step(0,1,0,0,0);
        chk("hour_again", set_field, 2'b01);
        sw_mode = 1'b0;
        step(0,0,1,0,0);
        chk("mode_exit", set_field, 2'b00);
        chk("mode_noinc", inc_p, 1'b0);
        chk("sw_kept_run", sw_run, 1'b1);

`ifdef SET_TIMEOUT_EN
        do_reset();
        sw_mode = 1'b1;
        repeat (3) step(0,1,0,0,0);
        step(0,0,0,0,1); step(0,0,0,0,1); step(0,0,0,0,1);
        chk("to_hold", set_field, 2'b11);
        step(0,0,0,0,0);
        chk("to_exit", set_field, 2'b00);
        repeat (3) step(0,1,0,0,0);
        step(0,0,0,0,1); step(0,0,0,0,1);
        step(0,0,1,0,0);
        step(0,0,0,0,1); step(0,0,0,0,1);
        step(0,0,0,0,0);
        chk("to_restart", set_field, 2'b11);
        step(0,0,0,0,1);
        step(0,0,0,0,0);
        chk("to_exit2", set_field, 2'b00);
`endif

        // randomized phase, including occasional asynchronous reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) sw_mode = ~sw_mode;
            rst       = ($urandom_range(0, 499) == 0);
            btn_run_p = ($urandom_range(0, 9) == 0);
            btn_clr_p = ($urandom_range(0, 5) == 0);
            btn_up_p  = ($urandom_range(0, 4) == 0);
            btn_dn_p  = ($urandom_range(0, 4) == 0);
            tick_1hz  = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        btn_run_p = 0; btn_clr_p = 0; btn_up_p = 0; btn_dn_p = 0; tick_1hz = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
